// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receiver with byte FIFO.
package uart_rx_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_CLKS_PER_BIT = 234;  // 27 MHz / 115200 baud
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the receiver: head byte, valid/ready, occupancy.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = uart_rx_pkg::DEF_FIFO_DEPTH
);

  logic [uart_rx_pkg::DATA_W-1:0] rx_data_o;
  logic                           rx_valid_o;
  logic                           rx_ready_i;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    output fifo_level_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    input  fifo_level_o,
    output rx_ready_i
  );

endinterface

// File: rtl/byte_fifo.sv
// Small power-of-two byte FIFO; a push on a full FIFO is accepted only when a
// pop happens in the same cycle. Head reads as zero while empty.
module byte_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic [DATA_W-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; the separate level count tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchronizer, baud-timed sampling FSM and output byte FIFO
// with sticky overflow and one-cycle framing-error pulse.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_i,
  input  logic           overflow_clr_i,
  output logic           frame_err_o,
  output logic           overflow_o,
  uart_rx_fifo_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic              rx_sync_p0;
  logic              rx_s;
  rx_state_t         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_s       <= rx_sync_p0;
    end
  end

  // Bit-timing FSM: half-bit to the start-bit centre, then full bits to each later centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LSB-first shift register, loaded at each data-bit centre.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == LAST_CNT) shift <= {rx_s, shift[DATA_W-1:1]};
  end

  assign push = (state == STOP) && (cnt == LAST_CNT) && rx_s;
  assign pop  = bus.rx_valid_o && bus.rx_ready_i;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .head      (head)
  );

  assign bus.rx_valid_o   = !empty;
  assign bus.rx_data_o    = head;
  assign bus.fifo_level_o = level;

  // Sticky overflow: a dropped byte sets it, and setting beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (push && full && !pop) begin
      overflow_o <= 1'b1;
    end else if (overflow_clr_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, FIFO contents checked against a queue model.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int CLKS  = 234;
  localparam int DEPTH = 4;
  // Clock edges from the start-bit drive to the push edge: 2 sync flops, one
  // cycle to leave IDLE, half a bit to the start centre, then 9 full bits.
  localparam int PUSH_EDGE = 3 + CLKS / 2 + 9 * CLKS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i = 1'b1;
  logic overflow_clr_i = 1'b0;
  logic frame_err_o;
  logic overflow_o;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_i           (rx_i),
    .overflow_clr_i (overflow_clr_i),
    .frame_err_o    (frame_err_o),
    .overflow_o     (overflow_o),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  int fe_pulses = 0;
  int fe_len = 0;
  int fe_max = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe valid rising edges and frame-error pulse widths.
  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1 && prev_valid !== 1'b1) rise_cyc <= cyc;
    prev_valid <= bus.rx_valid_o;
    if (frame_err_o === 1'b1) begin
      fe_len <= fe_len + 1;
    end else if (fe_len > 0) begin
      fe_pulses <= fe_pulses + 1;
      if (fe_len > fe_max) fe_max <= fe_len;
      fe_len <= 0;
    end
  end

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endfunction

  // Drive one frame; optionally pulse ready or overflow-clear in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits,
                            input bit pulse_ready, input bit pulse_clr, output int t0);
    int nbits;
    int bi;
    logic [7:0] tmp;
    tmp = b;
    nbits = 10 + stop_bits;
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < nbits * CLKS; k++) begin
      if (k > 0) @(negedge clk);
      bi = k / CLKS;
      if (bi == 0) rx_i = 1'b0;
      else if (bi <= 8) rx_i = tmp[bi-1];
      else if (bi <= 8 + stop_bits) rx_i = stop_v;
      else rx_i = 1'b1;
      if (k == PUSH_EDGE - 1) begin
        if (pulse_ready) bus.rx_ready_i = 1'b1;
        if (pulse_clr) overflow_clr_i = 1'b1;
      end else if (k == PUSH_EDGE) begin
        bus.rx_ready_i = 1'b0;
        overflow_clr_i = 1'b0;
      end
    end
  endtask

  // Pop with random ready, comparing every cycle to the model queue.
  task automatic drain_check(input string name);
    int guard;
    logic r;
    guard = 0;
    bus.rx_ready_i = 1'b0;
    while (exp_q.size() > 0 && guard < 64) begin
      @(negedge clk);
      total++;
      if (bus.fifo_level_o !== 3'(exp_q.size())) $display("FAIL %s_level: got %0d, expected %0d", name, bus.fifo_level_o, exp_q.size());
      else passed++;
      total++;
      if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== exp_q[0])
        $display("FAIL %s_data: got valid=%b data=%h, expected valid=1 data=%h", name, bus.rx_valid_o, bus.rx_data_o, exp_q[0]);
      else passed++;
      r = 1'($urandom_range(0, 1));
      bus.rx_ready_i = r;
      if (r) void'(exp_q.pop_front());
      guard++;
    end
    total++;
    if (guard >= 64) $display("FAIL %s_timeout: got %0d bytes left, expected 0", name, exp_q.size());
    else passed++;
    bus.rx_ready_i = 1'b1;  // ready while empty must do nothing
    repeat (2) @(negedge clk);
    total++;
    if (bus.fifo_level_o !== 3'd0 || bus.rx_valid_o !== 1'b0 || bus.rx_data_o !== 8'h00)
      $display("FAIL %s_empty: got level=%0d valid=%b data=%h, expected 0/0/00", name, bus.fifo_level_o, bus.rx_valid_o, bus.rx_data_o);
    else passed++;
    bus.rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.rx_valid_o !== 1'b0 || bus.rx_data_o !== 8'h00 || bus.fifo_level_o !== 3'd0)
      $display("FAIL reset_fifo: got valid=%b data=%h level=%0d, expected 0/00/0", bus.rx_valid_o, bus.rx_data_o, bus.fifo_level_o);
    else passed++;
    total++;
    if (frame_err_o !== 1'b0 || overflow_o !== 1'b0)
      $display("FAIL reset_flags: got fe=%b ovf=%b, expected 0/0", frame_err_o, overflow_o);
    else passed++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    int fe0;
    fe0 = fe_pulses;
    send_frame(8'h55, 1'b1, 1, 1'b0, 1'b0, t0);
    model_push(8'h55);
    total++;
    if (rise_cyc - t0 !== PUSH_EDGE) $display("FAIL single_latency: got %0d, expected %0d", rise_cyc - t0, PUSH_EDGE);
    else passed++;
    total++;
    if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 8'h55 || bus.fifo_level_o !== 3'd1)
      $display("FAIL single_out: got valid=%b data=%h level=%0d, expected 1/55/1", bus.rx_valid_o, bus.rx_data_o, bus.fifo_level_o);
    else passed++;
    total++;
    if (fe_pulses !== fe0) $display("FAIL single_fe: got %0d pulses, expected %0d", fe_pulses, fe0);
    else passed++;
    drain_check("single");
  endtask

  task automatic test_overflow();
    int t0;
    logic [7:0] msg [5];
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) begin
      send_frame(msg[i], 1'b1, 1, 1'b0, 1'b0, t0);
      model_push(msg[i]);
    end
    total++;
    if (bus.fifo_level_o !== 3'(exp_q.size())) $display("FAIL ovf_level: got %0d, expected %0d", bus.fifo_level_o, exp_q.size());
    else passed++;
    total++;
    if (overflow_o !== exp_ovf) $display("FAIL ovf_flag: got %b, expected %b", overflow_o, exp_ovf);
    else passed++;
    drain_check("ovf");
    total++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", overflow_o);
    else passed++;
    @(negedge clk); overflow_clr_i = 1'b1;
    @(negedge clk); overflow_clr_i = 1'b0;
    exp_ovf = 1'b0;
    total++;
    if (overflow_o !== exp_ovf) $display("FAIL ovf_clear: got %b, expected %b", overflow_o, exp_ovf);
    else passed++;
  endtask

  task automatic test_glitch();
    int t0;
    int fe0;
    fe0 = fe_pulses;
    @(negedge clk); rx_i = 1'b0;
    repeat (50) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    total++;
    if (bus.rx_valid_o !== 1'b0 || bus.fifo_level_o !== 3'd0 || fe_pulses !== fe0)
      $display("FAIL glitch_none: got valid=%b level=%0d fe=%0d, expected 0/0/%0d", bus.rx_valid_o, bus.fifo_level_o, fe_pulses, fe0);
    else passed++;
    send_frame(8'h7E, 1'b1, 1, 1'b0, 1'b0, t0);
    model_push(8'h7E);
    total++;
    if (rise_cyc - t0 !== PUSH_EDGE) $display("FAIL glitch_latency: got %0d, expected %0d", rise_cyc - t0, PUSH_EDGE);
    else passed++;
    drain_check("glitch");
  endtask

  task automatic test_frame_err();
    int t0;
    int fe0;
    fe0 = fe_pulses;
    send_frame(8'hA5, 1'b0, 3, 1'b0, 1'b0, t0);
    repeat (4) @(negedge clk);
    total++;
    if (fe_pulses !== fe0 + 1 || fe_max !== 1)
      $display("FAIL ferr_pulse: got pulses=%0d width=%0d, expected %0d/1", fe_pulses, fe_max, fe0 + 1);
    else passed++;
    total++;
    if (bus.fifo_level_o !== 3'(exp_q.size()) || overflow_o !== exp_ovf)
      $display("FAIL ferr_level: got level=%0d ovf=%b, expected %0d/%b", bus.fifo_level_o, overflow_o, exp_q.size(), exp_ovf);
    else passed++;
    send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b0, t0);
    model_push(8'h5A);
    drain_check("ferr");
  endtask

  task automatic test_random();
    int t0;
    int n;
    logic [7:0] b;
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1, 1, 1'b0, 1'b0, t0);
        model_push(b);
      end
      total++;
      if (bus.fifo_level_o !== 3'(exp_q.size()) || overflow_o !== exp_ovf)
        $display("FAIL rand_state: got level=%0d ovf=%b, expected %0d/%b", bus.fifo_level_o, overflow_o, exp_q.size(), exp_ovf);
      else passed++;
      drain_check("rand");
      @(negedge clk); overflow_clr_i = 1'b1;
      @(negedge clk); overflow_clr_i = 1'b0;
      exp_ovf = 1'b0;
      total++;
      if (overflow_o !== exp_ovf) $display("FAIL rand_clear: got %b, expected 0", overflow_o);
      else passed++;
    end
  endtask

  task automatic test_full_pop();
    int t0;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1, 1'b0, 1'b0, t0);
      model_push(b);
    end
    // Pop the head exactly in the cycle the fifth byte is pushed.
    send_frame(8'h99, 1'b1, 1, 1'b1, 1'b0, t0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    total++;
    if (bus.fifo_level_o !== 3'(DEPTH) || overflow_o !== 1'b0)
      $display("FAIL fullpop_state: got level=%0d ovf=%b, expected %0d/0", bus.fifo_level_o, overflow_o, DEPTH);
    else passed++;
    // Clear in the same cycle as a dropping push: the set must win.
    send_frame(8'h77, 1'b1, 1, 1'b0, 1'b1, t0);
    model_push(8'h77);
    total++;
    if (overflow_o !== exp_ovf || bus.fifo_level_o !== 3'(DEPTH))
      $display("FAIL setwins: got ovf=%b level=%0d, expected %b/%0d", overflow_o, bus.fifo_level_o, exp_ovf, DEPTH);
    else passed++;
    drain_check("fullpop");
  endtask

  task automatic test_reset_mid();
    int t0;
    int bi;
    logic [7:0] c3;
    c3 = 8'hC3;
    send_frame(8'h11, 1'b1, 1, 1'b0, 1'b0, t0);
    model_push(8'h11);
    @(negedge clk);
    for (int k = 0; k < 4 * CLKS + CLKS / 2; k++) begin
      if (k > 0) @(negedge clk);
      bi = k / CLKS;
      rx_i = (bi == 0) ? 1'b0 : c3[bi-1];
    end
    rst_n = 1'b0;
    rx_i = 1'b1;
    #1;
    total++;
    if (bus.rx_valid_o !== 1'b0 || bus.rx_data_o !== 8'h00 || bus.fifo_level_o !== 3'd0)
      $display("FAIL rstmid_fifo: got valid=%b data=%h level=%0d, expected 0/00/0", bus.rx_valid_o, bus.rx_data_o, bus.fifo_level_o);
    else passed++;
    total++;
    if (frame_err_o !== 1'b0 || overflow_o !== 1'b0)
      $display("FAIL rstmid_flags: got fe=%b ovf=%b, expected 0/0", frame_err_o, overflow_o);
    else passed++;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    total++;
    if (bus.rx_valid_o !== 1'b0 || fe_len !== 0) $display("FAIL rstmid_idle: got valid=%b fe=%0d, expected 0/0", bus.rx_valid_o, fe_len);
    else passed++;
    send_frame(8'h3C, 1'b1, 1, 1'b0, 1'b0, t0);
    model_push(8'h3C);
    total++;
    if (rise_cyc - t0 !== PUSH_EDGE || bus.rx_data_o !== 8'h3C)
      $display("FAIL rstmid_rx: got lat=%0d data=%h, expected %0d/3c", rise_cyc - t0, bus.rx_data_o, PUSH_EDGE);
    else passed++;
    drain_check("rstmid");
  endtask

  initial begin
    bus.rx_ready_i = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_glitch();
    test_frame_err();
    test_random();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk cycles per UART bit (27 MHz / 115200); SHALL be at least 16.
REQ-002 Parameter FIFO_DEPTH, default 4, received-byte buffer entries; SHALL be a power of two.
REQ-003 clk  input  1  system clock, single domain; all logic SHALL run on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  input  1  asynchronous UART line, 8N1, LSB first, idle high.
REQ-006 rx_data_o  output  8  FIFO head byte.
REQ-007 rx_valid_o  output  1  FIFO non-empty.
REQ-008 rx_ready_i  input  1  consumer accepts head byte.
REQ-009 fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-010 frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-011 overflow_o  output  1  sticky flag, byte dropped on full FIFO.
REQ-012 overflow_clr_i  input  1  synchronous clear of overflow_o.

Function
REQ-013 rx_i SHALL pass a 2-flop synchronizer (reset value 1) before any use; all references below are to the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-015 IDLE: rx_s==0 -> START, bit counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, sample rx_s; 1 -> IDLE (glitch, no output); 0 -> DATA, counter cleared.
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles into shift register LSB first; after 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> push byte, -> IDLE; 0 -> frame_err_o high exactly one cycle, byte discarded, -> RECOVER.
REQ-019 RECOVER: stay until rx_s==1, then -> IDLE.
REQ-020 Pushed byte SHALL appear on rx_data_o with rx_valid_o=1 the cycle after the stop-bit sample cycle when FIFO was empty.
REQ-021 Pop SHALL occur on cycle where rx_valid_o && rx_ready_i; bytes SHALL leave in arrival order.
REQ-022 rx_data_o SHALL be 8'h00 whenever rx_valid_o==0.
REQ-023 Push on full FIFO without same-cycle pop: byte dropped, overflow_o set, contents unchanged.
REQ-024 Push and pop same cycle (any level incl. full): both occur, level unchanged, no overflow.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level_o SHALL distinguish full from empty.
REQ-026 overflow_clr_i and a same-cycle overflow event: set wins.
REQ-027 rx_ready_i when empty SHALL have no effect.

Reset
REQ-028 rst_n low SHALL asynchronously force: FSM IDLE, counters 0, FIFO empty, rx_valid_o 0, rx_data_o 8'h00, fifo_level_o 0, frame_err_o 0, overflow_o 0, synchronizer 1.
REQ-029 Reset mid-byte SHALL discard the partial byte; reception SHALL resume on the next start bit after release.

Structure
REQ-030 Package uart_rx_pkg SHALL hold the FSM state typedef and default CLKS_PER_BIT/FIFO_DEPTH constants.
REQ-031 FIFO storage and pointers SHALL be sub-module byte_fifo (push/pop/full/empty/level); FSM, synchronizer and baud counter stay in uart_rx_fifo.

Verification (CLKS_PER_BIT=234, FIFO_DEPTH=4)
REQ-032 Send 0x55, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x55, fifo_level_o=1 one cycle after stop sample; no frame_err_o.
REQ-033 Send 0x48,0x45,0x4C,0x4C,0x4F with rx_ready_i=0 -> level 4, overflow_o=1 after 5th stop; drain returns 0x48,0x45,0x4C,0x4C; level 0; overflow_clr_i clears flag.
REQ-034 rx_i low 50 cycles then high -> FSM returns IDLE, no push, no frame_err_o; next byte 0x7E received correctly.
REQ-035 Send 0xA5 with stop bit 0 held 3 bit times -> frame_err_o one cycle, level unchanged; following 0x5A received correctly.
REQ-036 Fill 4 bytes, hold rx_ready_i=1 while 5th byte 0x99 stops -> no overflow, level stays 4, 0x99 last out.
REQ-037 Assert rst_n low during bit 3 of 0xC3 -> all outputs at reset values; after release 0x3C received correctly.
